// File: rtl/pushbutton_in_port_pkg.sv
// Shared constants for the 4-bit uP input-port path (button width, debounce defaults).
package pushbutton_in_port_pkg;

    localparam int unsigned IO_WIDTH            = 4;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 8;
    localparam int unsigned CNT_W_DEF           = 4;

    typedef logic [IO_WIDTH-1:0] nibble_t;

endpackage : pushbutton_in_port_pkg

// File: rtl/pushbutton_in_port_debounce_bit.sv
// One button bit: two-flop synchronizer, stability counter and debounced level.
// rise_c flags the edge at which the debounced level is about to go 0->1.
module debounce_bit
    import pushbutton_in_port_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic rise_c
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             differ_c;
    logic             expire_c;

    // Qualify a level change once it has persisted for DEBOUNCE_CYCLES edges.
    always_comb begin
        differ_c = (sync2 != stable);
        expire_c = differ_c && (cnt == CNT_MAX);
        rise_c   = expire_c && sync2;
    end

    // Metastability guard for the asynchronous button input.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Count consecutive disagreeing cycles; any agreement restarts the count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (!differ_c) begin
            cnt    <= '0;
        end else if (expire_c) begin
            cnt    <= '0;
            stable <= sync2;
        end else begin
            cnt    <= cnt + CNT_W'(1);
        end
    end

endmodule : debounce_bit

// File: rtl/pushbutton_in_port.sv
// uP IN-port responder: debounced pushbutton nibble presented on the data bus during reads.
// Optional build macro PB_STICKY_LATCH_EN: presses are latched until the uP reads them;
// without it the port reports the live debounced level and reads have no side effect.
module pushbutton_in_port
    import pushbutton_in_port_pkg::*;
#(
    parameter int unsigned WIDTH           = IO_WIDTH,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] buttons_raw,
    input  logic             rd_en,
    output logic [WIDTH-1:0] data_out,
    output logic             data_oe,
    output logic             event_pending
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] rise_c;

    // Independent debouncer per button bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce_bit (
            .clock  (clock),
            .reset  (reset),
            .raw    (buttons_raw[i]),
            .stable (stable[i]),
            .rise_c (rise_c[i])
        );
    end

`ifdef PB_STICKY_LATCH_EN
    logic [WIDTH-1:0] sticky;

    // Latch presses until read; a press landing on the read edge survives it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sticky <= '0;
        end else begin
            sticky <= (sticky & ~{WIDTH{rd_en}}) | rise_c;
        end
    end

    // Report latched presses together with buttons still held.
    always_comb begin
        data_out = sticky | stable;
    end
`else
    logic unused_rise;

    // Level mode: report the live debounced buttons.
    always_comb begin
        data_out    = stable;
        unused_rise = ^rise_c;
    end
`endif

    // Bus enable follows the read strobe in the same cycle; poll flag from presented nibble.
    always_comb begin
        data_oe       = rd_en;
        event_pending = |data_out;
    end

endmodule : pushbutton_in_port

// File: tb/tb_pushbutton_in_port.sv
// Scoreboard bench for pushbutton_in_port: directed scenarios plus randomized button activity.
module tb_pushbutton_in_port;

    localparam int unsigned W  = 4;
    localparam int unsigned DB = 8;

    logic         clock;
    logic         reset;
    logic [W-1:0] buttons_raw;
    logic         rd_en;
    logic [W-1:0] data_out;
    logic         data_oe;
    logic         event_pending;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] sb[$];

    pushbutton_in_port #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .buttons_raw   (buttons_raw),
        .rd_en         (rd_en),
        .data_out      (data_out),
        .data_oe       (data_oe),
        .event_pending (event_pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: a level is accepted once the synchronized input has
    // disagreed with it for the last DB consecutive clock edges.
    logic [W-1:0] m_s1, m_s2, m_stable, m_sticky;
    logic [W-1:0] m_win[$];

    always @(posedge clock or negedge reset) begin
        logic [W-1:0] rose;
        if (!reset) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_sticky = '0;
            m_win.delete();
        end else begin
            rose = '0;
            m_win.push_back(m_s2);
            if (m_win.size() > DB) void'(m_win.pop_front());
            if (m_win.size() == DB) begin
                for (int b = 0; b < W; b++) begin
                    bit all_diff;
                    all_diff = 1'b1;
                    foreach (m_win[k]) if (m_win[k][b] == m_stable[b]) all_diff = 1'b0;
                    if (all_diff) begin
                        m_stable[b] = ~m_stable[b];
                        if (m_stable[b]) rose[b] = 1'b1;
                    end
                end
            end
            if (rd_en) m_sticky = '0;
            m_sticky = m_sticky | rose;
            m_s2 = m_s1;
            m_s1 = buttons_raw;
        end
    end

    function automatic logic [W-1:0] model_out();
`ifdef PB_STICKY_LATCH_EN
        return m_sticky | m_stable;
`else
        return m_stable;
`endif
    endfunction

    // Monitor: enable must track the strobe; each bus presentation pops one expectation.
    always @(negedge clock) begin
        logic [W-1:0] exp;
        #3;
        checks++;
        if (data_oe !== rd_en) begin
            errors++;
            $display("FAIL data_oe t=%0t got %b want %b", $time, data_oe, rd_en);
        end
        if (data_oe === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read t=%0t data_out %b with empty scoreboard", $time, data_out);
            end else begin
                exp = sb.pop_front();
                if (data_out !== exp || event_pending !== (|exp)) begin
                    errors++;
                    $display("FAIL read_data t=%0t got %b/%b want %b/%b",
                             $time, data_out, event_pending, exp, |exp);
                end
            end
        end
    end

    task automatic do_read(input logic [W-1:0] exp);
        rd_en = 1'b1;
        sb.push_back(exp);
        @(negedge clock);
        rd_en = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (data_out !== '0 || data_oe !== 1'b0 || event_pending !== 1'b0) begin
            errors++;
            $display("FAIL %s got %b/%b/%b want 0000/0/0", name, data_out, data_oe, event_pending);
        end
    endtask

    initial begin
        reset       = 1'b0;
        buttons_raw = 4'b0110;
        rd_en       = 1'b0;

        // Reset state, then release: nibble appears 9 edges after first sampling edge.
        #1;
        check_reset_outputs("reset_state");
        wait_cycles(2);
        reset = 1'b1;
        wait_cycles(9);
        do_read(4'b0000);
        do_read(4'b0110);

        // Short glitch on bit0 must be rejected.
        buttons_raw = 4'b0111;
        wait_cycles(5);
        buttons_raw = 4'b0110;
        for (int i = 0; i < 8; i++) begin
            wait_cycles(1);
            do_read(4'b0110);
        end

        // Single read strobe.
        wait_cycles(3);
        do_read(4'b0110);
        wait_cycles(3);

`ifdef PB_STICKY_LATCH_EN
        // Latched press survives release and is cleared by a read.
        buttons_raw = 4'b1110;
        wait_cycles(12);
        buttons_raw = 4'b0110;
        wait_cycles(20);
        do_read(4'b1110);
        do_read(4'b0110);

        // Read coinciding with a bit2 rising edge keeps bit2 and clears bit3.
        buttons_raw = 4'b0010;
        wait_cycles(20);
        buttons_raw = 4'b1010;
        wait_cycles(12);
        buttons_raw = 4'b0010;
        wait_cycles(20);
        buttons_raw = 4'b0110;
        wait_cycles(9);
        do_read(4'b1010);
        buttons_raw = 4'b0010;
        wait_cycles(20);
        do_read(4'b0110);
        do_read(4'b0010);
`endif

        // Reset mid-debounce: outputs clear at once, held buttons re-qualify fully.
        buttons_raw = 4'b0100;
        wait_cycles(20);
        do_read(4'b0100);
        buttons_raw = 4'b0110;
        wait_cycles(7);
        reset = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        wait_cycles(1);
        reset = 1'b1;
        wait_cycles(9);
        do_read(4'b0000);
        do_read(4'b0110);

        // Random button activity and reads against the model.
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < W; b++)
                if ($urandom_range(0, 11) == 0) buttons_raw[b] = ~buttons_raw[b];
            if ($urandom_range(0, 3) == 0) do_read(model_out());
            else wait_cycles(1);
        end

        wait_cycles(3);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pushbutton_in_port
